// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared state encoding and default sizing for the clock period meter
package clk_meas_pkg;
  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT = 1000000;
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with one history flop for rise/fall detection
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic s_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_d <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      s_d <= sync[STAGES-1];
    end
  end
  assign rise = sync[STAGES-1] & ~s_d;
  assign fall = ~sync[STAGES-1] & s_d;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an async signal in clk_in cycles
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] SAT = '1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  logic rise, fall;
  logic [CNT_W-1:0] cnt, hi_latch;
  state_t state;
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_in),
    .rst(rst),
    .d(sig_in),
    .rise(rise),
    .fall(fall)
  );
  // a rise always restarts the count, so it wins over a coincident timeout
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= '0;
      hi_latch <= '0;
      state <= IDLE;
      meas_valid <= 1'b0;
      period <= '0;
      high_time <= '0;
      locked <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cnt <= rise ? CNT_W'(1) : (cnt == SAT ? cnt : cnt + CNT_W'(1));
      meas_valid <= 1'b0;
      if (rise) begin
        state <= MEAS_HIGH;
        if (state == MEAS_LOW) begin
          period <= cnt;
          high_time <= hi_latch;
          meas_valid <= 1'b1;
          locked <= 1'b1;
          timeout <= 1'b0;
        end
      end else if (cnt == TO_CNT) begin
        timeout <= 1'b1;
        locked <= 1'b0;
        state <= IDLE;
        hi_latch <= '0;
      end else if (fall && state == MEAS_HIGH) begin
        hi_latch <= cnt;
        state <= MEAS_LOW;
      end
    end
  end
endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/10ps
// tb_clk_period_meter: directed checks of period, high time, lock, timeout and reset behaviour
module tb_clk_period_meter;
  logic clk_in = 1'b0, rst = 1'b1, sig_in = 1'b0;
  logic meas_valid, locked, timeout;
  logic [31:0] period, high_time;
  int checks = 0, errors = 0;
  int cyc = 0, npulse = 0, last_mv = 0, gap = 0, to_cyc = 0, bad73 = 0, sum73 = 0;
  logic to_prev = 1'b0, mon73 = 1'b0;
  int p0;

  clk_period_meter #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(100)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .sig_in(sig_in),
    .meas_valid(meas_valid),
    .period(period),
    .high_time(high_time),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // records pulse count/spacing and the cycle timeout rose, sampled mid-cycle
  always @(negedge clk_in) begin
    to_prev <= timeout;
    if (timeout && !to_prev) to_cyc <= cyc;
    if (meas_valid) begin
      npulse <= npulse + 1;
      gap <= cyc - last_mv;
      last_mv <= cyc;
      if (mon73) begin
        sum73 <= sum73 + int'(period);
        if (period != 7 && period != 8) bad73 <= bad73 + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sq(input int h, input int l, input int n);
    repeat (n) begin
      sig_in = 1'b1;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    // divide-by-4, 50% duty
    p0 = npulse;
    sq(2, 2, 6);
    chk("div4_pulses", npulse - p0, 5);
    chk("div4_period", period, 4);
    chk("div4_high", high_time, 2);
    chk("div4_locked", 32'(locked), 1);
    chk("div4_gap", gap, 4);
    chk("div4_timeout", 32'(timeout), 0);
    // divide-by-5, 2 high / 3 low
    reset_dut();
    p0 = npulse;
    sq(2, 3, 1);
    chk("div5_arm_only", npulse - p0, 0);
    chk("div5_unlocked", 32'(locked), 0);
    sq(2, 3, 5);
    chk("div5_pulses", npulse - p0, 5);
    chk("div5_period", period, 5);
    chk("div5_high", high_time, 2);
    chk("div5_gap", gap, 5);
    // loss of signal
    reset_dut();
    sq(2, 2, 4);
    chk("to_locked_before", 32'(locked), 1);
    repeat (110) tick();
    chk("to_flag", 32'(timeout), 1);
    chk("to_unlocked", 32'(locked), 0);
    chk("to_period_held", period, 4);
    chk("to_high_held", high_time, 2);
    chk("to_delay", to_cyc - last_mv, 100);
    p0 = npulse;
    sq(2, 2, 1);
    chk("relock_first_rise", npulse - p0, 0);
    chk("relock_timeout_sticky", 32'(timeout), 1);
    sq(2, 2, 1);
    chk("relock_second_rise", npulse - p0, 1);
    chk("relock_timeout_clr", 32'(timeout), 0);
    chk("relock_locked", 32'(locked), 1);
    chk("relock_period", period, 4);
    // reset while in MEAS_LOW
    sq(2, 2, 1);
    sig_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(meas_valid), 0);
    chk("midrst_period", period, 0);
    chk("midrst_high", high_time, 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_timeout", 32'(timeout), 0);
    p0 = npulse;
    sq(2, 2, 1);
    chk("midrst_first_rise", npulse - p0, 0);
    sq(2, 2, 1);
    chk("midrst_second_rise", npulse - p0, 1);
    chk("midrst_period_new", period, 4);
    // divide-by-2, minimum high and low
    reset_dut();
    p0 = npulse;
    sq(1, 1, 8);
    sig_in = 1'b0;
    repeat (4) tick();
    chk("div2_pulses", npulse - p0, 7);
    chk("div2_period", period, 2);
    chk("div2_high", high_time, 1);
    chk("div2_gap", gap, 2);
    // unrelated 7.3-cycle source, edges kept off the clock edges
    reset_dut();
    p0 = npulse;
    mon73 = 1'b1;
    #0.25;
    repeat (2002) #36.5 sig_in = ~sig_in;
    repeat (20) tick();
    mon73 = 1'b0;
    chk("async_pulses", npulse - p0, 1000);
    chk("async_bad_period", bad73, 0);
    chk("async_avg_1pct", 32'(sum73 >= 7227 && sum73 <= 7373), 1);
    chk("async_locked", 32'(locked), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
